// File: rtl/arm_pkg.sv
// Shared types and constants for the EXE/MEM-side SRAM controller.
`default_nettype none

package arm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned c_sram_dw           = 16;
    localparam logic [31:0] c_base_addr_default = 32'd1024;

endpackage

`default_nettype wire

// File: rtl/sram_addr_xlate.sv
// ============================================================================
//  Module   : sram_addr_xlate
//  Function : byte address -> low/high SRAM half-word addresses
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sram_addr_xlate #(
    parameter int          ADDR_W    = 18,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic [31:0]       address_i,
    output logic [ADDR_W-1:0] lo_addr_o,
    output logic [ADDR_W-1:0] hi_addr_o
);

    logic [31:0] w_offset;
    logic [31:0] w_word;

    // Offset wraps in 32 bits; the bottom two byte-lane bits drop out in the shift.
    assign w_offset  = address_i - BASE_ADDR;
    assign w_word    = w_offset >> 2;
    assign lo_addr_o = ADDR_W'({w_word[30:0], 1'b0});
    assign hi_addr_o = ADDR_W'({w_word[30:0], 1'b1});

endmodule

`default_nettype wire

// File: rtl/sram_mem_controller.sv
// ============================================================================
//  Module   : sram_mem_controller
//  Function : 32-bit load/store responder split into two 16-bit SRAM phases
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sram_mem_controller
    import arm_pkg::*;
#(
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = c_base_addr_default
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 ready,
    output logic [ADDR_W-1:0]    sram_addr,
    input  logic [c_sram_dw-1:0] sram_dq_i,
    output logic [c_sram_dw-1:0] sram_dq_o,
    output logic                 sram_dq_oe,
    output logic                 sram_we_n,
    output logic                 sram_oe_n
);

    localparam int c_cnt_w = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_e                 state_q, state_d;
    logic [c_cnt_w-1:0]     wait_cnt_q, wait_cnt_d;
    logic                   is_write_q, is_write_d;
    logic [ADDR_W-1:0]      hi_addr_q, hi_addr_d;
    logic [c_sram_dw-1:0]   wdata_hi_q, wdata_hi_d;
    logic [31:0]            read_data_q, read_data_d;
    logic [ADDR_W-1:0]      sram_addr_q, sram_addr_d;
    logic [c_sram_dw-1:0]   dq_o_q, dq_o_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   we_n_q, we_n_d;
    logic                   oe_n_q, oe_n_d;

    logic                   w_req;
    logic                   w_phase_end;
    logic                   w_op_write;
    logic                   w_drive;
    logic [ADDR_W-1:0]      w_lo_addr;
    logic [ADDR_W-1:0]      w_hi_addr;

    sram_addr_xlate #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_xlate (
        .address_i (address),
        .lo_addr_o (w_lo_addr),
        .hi_addr_o (w_hi_addr)
    );

    assign w_req       = rd_en | wr_en;
    assign w_phase_end = (wait_cnt_q == c_cnt_w'(WAIT_CYCLES));
    assign w_op_write  = (state_q == ST_IDLE) ? wr_en : is_write_q;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        is_write_d  = is_write_q;
        hi_addr_d   = hi_addr_q;
        wdata_hi_d  = wdata_hi_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        w_drive     = 1'b0;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    state_d     = ST_LO;
                    wait_cnt_d  = '0;
                    is_write_d  = wr_en;
                    hi_addr_d   = w_hi_addr;
                    wdata_hi_d  = write_data[31:16];
                    sram_addr_d = w_lo_addr;
                    dq_o_d      = write_data[15:0];
                end
            end
            ST_LO: begin
                if (w_phase_end) begin
                    state_d     = ST_HI;
                    wait_cnt_d  = '0;
                    sram_addr_d = hi_addr_q;
                    dq_o_d      = wdata_hi_q;
                    if (!is_write_q) begin
                        read_data_d[15:0] = sram_dq_i;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_HI: begin
                if (w_phase_end) begin
                    state_d    = ST_DONE;
                    wait_cnt_d = '0;
                    if (!is_write_q) begin
                        read_data_d[31:16] = sram_dq_i;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered, so they follow the state being entered.
        w_drive = (state_d == ST_LO) || (state_d == ST_HI);
        dq_oe_d = w_drive && w_op_write;
        we_n_d  = !(w_drive && w_op_write);
        oe_n_d  = !(w_drive && !w_op_write);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            is_write_q  <= 1'b0;
            hi_addr_q   <= '0;
            wdata_hi_q  <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            is_write_q  <= is_write_d;
            hi_addr_q   <= hi_addr_d;
            wdata_hi_q  <= wdata_hi_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

    assign ready      = !w_req || (state_q == ST_DONE);
    assign read_data  = read_data_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = oe_n_q;

endmodule

`default_nettype wire
